multicycle_sequencer: RTL and testbench

MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

---
 rtl/multicycle_sequencer.sv | 220 ++++++++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: control FSM for a multi-cycle RV32-style datapath.
// Walks FETCH -> DECODE -> class-specific states and drives mux selects
// and write enables. A wait counter bounds every memory request and
// traps the sequencer if memory never answers.
// Optional build macro: ILLEGAL_TRAP_EN -- unknown opcodes trap (cause 01)
// instead of retiring as a NOP.
//
// Memory handshake: Mem_Req_o is the valid, Mem_Ready_i is the ready; an
// access completes in exactly the cycle where both are high. Mem_Req_o
// stays high with stable IorD_o/Mem_Write_o until that cycle or until the
// wait counter expires. Ready in the expiry cycle still completes the access.
module multicycle_sequencer #(
  parameter int WAIT_MAX = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] OP_i,
  input  logic       Branch_Taken_i,
  input  logic       Mem_Ready_i,
  output logic       Mem_Req_o,
  output logic       Mem_Write_o,
  output logic       IorD_o,
  output logic       IR_Write_o,
  output logic       PC_Write_o,
  output logic       Reg_Write_o,
  output logic       ALU_Src_A_o,
  output logic [1:0] ALU_Src_B_o,
  output logic [2:0] ALU_Op_o,
  output logic [1:0] PC_Src_o,
  output logic [1:0] Mem_to_Reg_o,
  output logic [3:0] State_o,
  output logic       Trap_o,
  output logic [1:0] Trap_Cause_o,
  output logic       Retire_o
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC   = 4'd2,
    S_ADDR   = 4'd3,
    S_MEM_RD = 4'd4,
    S_MEM_WR = 4'd5,
    S_WB_ALU = 4'd6,
    S_WB_MEM = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_TRAP   = 4'd10
  } state_e;

  localparam logic [6:0] OP_R     = 7'h33;
  localparam logic [6:0] OP_I     = 7'h13;
  localparam logic [6:0] OP_AUIPC = 7'h17;
  localparam logic [6:0] OP_LUI   = 7'h37;
  localparam logic [6:0] OP_LOAD  = 7'h03;
  localparam logic [6:0] OP_STORE = 7'h23;
  localparam logic [6:0] OP_BR    = 7'h63;
  localparam logic [6:0] OP_JAL   = 7'h6F;
  localparam logic [6:0] OP_JALR  = 7'h67;

  // Last count value before expiry: WAIT_MAX unanswered request cycles trap.
  localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

  state_e      state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic [1:0]  trap_cause_q, trap_cause_d;
  logic        retire_q, retire_d;

  logic        mem_req, mem_write, iord, ir_write, pc_write, reg_write;
  logic        src_a;
  logic [1:0]  src_b, pc_src, mem_to_reg;
  logic [2:0]  alu_op;

  function automatic logic [2:0] alu_op_of(input logic [6:0] op);
    case (op)
      OP_R:     return 3'b000;
      OP_I:     return 3'b001;
      OP_AUIPC: return 3'b010;
      OP_LOAD:  return 3'b011;
      OP_STORE: return 3'b100;
      OP_BR:    return 3'b101;
      OP_LUI:   return 3'b110;
      default:  return 3'b000;
    endcase
  endfunction

  // Next-state, wait counter and per-state datapath controls.
  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    trap_cause_d = trap_cause_q;
    mem_req      = 1'b0;
    mem_write    = 1'b0;
    iord         = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    reg_write    = 1'b0;
    src_a        = 1'b0;
    src_b        = 2'b00;
    alu_op       = 3'b000;
    pc_src       = 2'b00;
    mem_to_reg   = 2'b00;

    case (state_q)
      S_FETCH: begin
        mem_req  = 1'b1;
        src_b    = 2'b01;
        ir_write = Mem_Ready_i;
        pc_write = Mem_Ready_i;
        if (Mem_Ready_i) state_d = S_DECODE;
      end
      S_DECODE: begin
        src_b = 2'b10;
        case (OP_i)
          OP_R, OP_I, OP_AUIPC, OP_LUI: state_d = S_EXEC;
          OP_LOAD, OP_STORE:            state_d = S_ADDR;
          OP_BR:                        state_d = S_BRANCH;
          OP_JAL, OP_JALR:              state_d = S_JUMP;
          default: begin
`ifdef ILLEGAL_TRAP_EN
            state_d      = S_TRAP;
            trap_cause_d = 2'b01;
`else
            state_d = S_FETCH;
`endif
          end
        endcase
      end
      S_EXEC: begin
        alu_op  = alu_op_of(OP_i);
        src_a   = (OP_i != OP_AUIPC);
        src_b   = (OP_i == OP_R) ? 2'b00 : 2'b10;
        state_d = S_WB_ALU;
      end
      S_ADDR: begin
        alu_op  = alu_op_of(OP_i);
        src_a   = 1'b1;
        src_b   = 2'b10;
        state_d = (OP_i == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD, S_MEM_WR: begin
        mem_req   = 1'b1;
        iord      = 1'b1;
        mem_write = (state_q == S_MEM_WR);
        if (Mem_Ready_i) state_d = (state_q == S_MEM_RD) ? S_WB_MEM : S_FETCH;
      end
      S_WB_ALU: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'b01;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alu_op   = alu_op_of(OP_i);
        pc_write = Branch_Taken_i;
        pc_src   = 2'b01;
        state_d  = S_FETCH;
      end
      S_JUMP: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'b10;
        pc_write   = 1'b1;
        pc_src     = (OP_i == OP_JALR) ? 2'b10 : 2'b01;
        state_d    = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase

    // Unanswered request: count, or trap once the budget is used up.
    if (mem_req && !Mem_Ready_i) begin
      if (wait_cnt_q == WAIT_LAST) begin
        state_d      = S_TRAP;
        trap_cause_d = 2'b10;
      end else begin
        wait_cnt_d = wait_cnt_q + 8'd1;
      end
    end
    // Every state change starts a fresh wait budget.
    if (state_d != state_q) wait_cnt_d = 8'd0;

    retire_d = (state_d == S_FETCH) && (state_q != S_FETCH) && (state_q != S_TRAP);
  end

  // State, wait counter, trap cause and retire pulse registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_FETCH;
      wait_cnt_q   <= 8'd0;
      trap_cause_q <= 2'b00;
      retire_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      trap_cause_q <= trap_cause_d;
      retire_q     <= retire_d;
    end
  end

  // Enables are forced low while reset is held so nothing is written.
  assign Mem_Req_o    = reset & mem_req;
  assign Mem_Write_o  = reset & mem_write;
  assign IR_Write_o   = reset & ir_write;
  assign PC_Write_o   = reset & pc_write;
  assign Reg_Write_o  = reset & reg_write;
  assign Retire_o     = reset & retire_q;
  assign IorD_o       = iord;
  assign ALU_Src_A_o  = src_a;
  assign ALU_Src_B_o  = src_b;
  assign ALU_Op_o     = alu_op;
  assign PC_Src_o     = pc_src;
  assign Mem_to_Reg_o = mem_to_reg;
  assign State_o      = state_q;
  assign Trap_o       = (state_q == S_TRAP);
  assign Trap_Cause_o = trap_cause_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb_multicycle_sequencer: per-cycle scoreboard for multicycle_sequencer.
// The driver walks each instruction through its phases as listed by the
// opcode rules, pushing the expected output vector for every cycle; a
// negedge monitor pops and compares against the DUT.
module tb_multicycle_sequencer;
  localparam int WAIT_MAX = 8;

  localparam logic [3:0] ST_FETCH  = 4'd0;
  localparam logic [3:0] ST_DECODE = 4'd1;
  localparam logic [3:0] ST_EXEC   = 4'd2;
  localparam logic [3:0] ST_ADDR   = 4'd3;
  localparam logic [3:0] ST_MEM_RD = 4'd4;
  localparam logic [3:0] ST_MEM_WR = 4'd5;
  localparam logic [3:0] ST_WB_ALU = 4'd6;
  localparam logic [3:0] ST_WB_MEM = 4'd7;
  localparam logic [3:0] ST_BRANCH = 4'd8;
  localparam logic [3:0] ST_JUMP   = 4'd9;
  localparam logic [3:0] ST_TRAP   = 4'd10;

  typedef struct packed {
    logic [3:0] st;
    logic       req, wr, iord, irw, pcw, rw, srca;
    logic [1:0] srcb;
    logic [2:0] aluop;
    logic [1:0] pcsrc, m2r;
    logic       trap;
    logic [1:0] cause;
    logic       retire;
  } out_t;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] OP_i;
  logic       Branch_Taken_i, Mem_Ready_i;
  logic       Mem_Req_o, Mem_Write_o, IorD_o, IR_Write_o, PC_Write_o, Reg_Write_o;
  logic       ALU_Src_A_o;
  logic [1:0] ALU_Src_B_o, PC_Src_o, Mem_to_Reg_o, Trap_Cause_o;
  logic [2:0] ALU_Op_o;
  logic [3:0] State_o;
  logic       Trap_o, Retire_o;

  always #5 clk = ~clk;

  multicycle_sequencer #(.WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .reset(reset), .OP_i(OP_i), .Branch_Taken_i(Branch_Taken_i),
    .Mem_Ready_i(Mem_Ready_i), .Mem_Req_o(Mem_Req_o), .Mem_Write_o(Mem_Write_o),
    .IorD_o(IorD_o), .IR_Write_o(IR_Write_o), .PC_Write_o(PC_Write_o),
    .Reg_Write_o(Reg_Write_o), .ALU_Src_A_o(ALU_Src_A_o), .ALU_Src_B_o(ALU_Src_B_o),
    .ALU_Op_o(ALU_Op_o), .PC_Src_o(PC_Src_o), .Mem_to_Reg_o(Mem_to_Reg_o),
    .State_o(State_o), .Trap_o(Trap_o), .Trap_Cause_o(Trap_Cause_o), .Retire_o(Retire_o)
  );

  // ---------------- scoreboard state ----------------
  logic [23:0] exp_q[$];
  string       tag_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [1:0]  cur_cause = 2'b00;
  bit          retire_pending = 1'b0;
  bit          rdy_one = 1'b0;

  function automatic out_t blank(input logic [3:0] st);
    out_t e;
    e       = '0;
    e.st    = st;
    e.cause = cur_cause;
    return e;
  endfunction

  function automatic logic [2:0] exp_alu_op(input logic [6:0] op);
    case (op)
      7'h33: return 3'b000;
      7'h13: return 3'b001;
      7'h17: return 3'b010;
      7'h03: return 3'b011;
      7'h23: return 3'b100;
      7'h63: return 3'b101;
      7'h37: return 3'b110;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Ready level in cycles where no request is outstanding.
  function automatic logic idle_rdy();
    return rdy_one ? 1'b1 : rbit();
  endfunction

  // ---------------- monitor ----------------
  logic [23:0] mon_exp, mon_got;
  string       mon_tag;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_tag = tag_q.pop_front();
      mon_got = {State_o, Mem_Req_o, Mem_Write_o, IorD_o, IR_Write_o, PC_Write_o,
                 Reg_Write_o, ALU_Src_A_o, ALU_Src_B_o, ALU_Op_o, PC_Src_o,
                 Mem_to_Reg_o, Trap_o, Trap_Cause_o, Retire_o};
      checks++;
      if (mon_got !== mon_exp) begin
        errors++;
        $display("FAIL %s @%0t: got=%h exp=%h (state got %0d exp %0d)",
                 mon_tag, $time, mon_got, mon_exp, mon_got[23:20], mon_exp[23:20]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic rdy, input logic tkn, input out_t e, input string tag);
    Mem_Ready_i    = rdy;
    Branch_Taken_i = tkn;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  // Two reset cycles: the first still shows the old state with enables off,
  // the second shows FETCH with enables off.
  task automatic do_reset(input out_t first);
    out_t e;
    reset    = 1'b0;
    e        = first;
    e.req    = 1'b0;
    e.wr     = 1'b0;
    e.irw    = 1'b0;
    e.pcw    = 1'b0;
    e.rw     = 1'b0;
    e.retire = 1'b0;
    step(rbit(), rbit(), e, "rst_first");
    cur_cause = 2'b00;
    e      = blank(ST_FETCH);
    e.srcb = 2'b01;
    step(rbit(), rbit(), e, "rst_hold");
    reset          = 1'b1;
    retire_pending = 1'b0;
  endtask

  task automatic enter_trap(input logic [1:0] cause);
    out_t e;
    int   n;
    cur_cause = cause;
    n = $urandom_range(2, 4);
    e = blank(ST_TRAP);
    for (int i = 0; i < n; i++) begin
      e      = blank(ST_TRAP);
      e.trap = 1'b1;
      OP_i   = 7'($urandom);
      step(rbit(), rbit(), e, "trap");
    end
    do_reset(e);
  endtask

  // One instruction: fwait/mwait are unanswered request cycles before ready
  // (>= WAIT_MAX means a timeout); abort_at resets during the data access.
  task automatic run_instr(input logic [6:0] op, input int fwait, input int mwait,
                           input logic tkn, input int abort_at);
    out_t e;
    bit   is_load;
    for (int k = 0; k <= fwait; k++) begin
      e        = blank(ST_FETCH);
      e.req    = 1'b1;
      e.srcb   = 2'b01;
      e.retire = (k == 0) && retire_pending;
      e.irw    = (k == fwait);
      e.pcw    = (k == fwait);
      retire_pending = 1'b0;
      OP_i = 7'($urandom);
      step(k == fwait, rbit(), e, "fetch");
      if (k != fwait && k == WAIT_MAX - 1) begin
        enter_trap(2'b10);
        return;
      end
    end
    OP_i   = op;
    e      = blank(ST_DECODE);
    e.srcb = 2'b10;
    step(idle_rdy(), rbit(), e, "decode");
    case (op)
      7'h33, 7'h13, 7'h17, 7'h37: begin
        e       = blank(ST_EXEC);
        e.srca  = (op != 7'h17);
        e.srcb  = (op == 7'h33) ? 2'b00 : 2'b10;
        e.aluop = exp_alu_op(op);
        step(idle_rdy(), rbit(), e, "exec");
        e    = blank(ST_WB_ALU);
        e.rw = 1'b1;
        step(idle_rdy(), rbit(), e, "wb_alu");
        retire_pending = 1'b1;
      end
      7'h03, 7'h23: begin
        is_load = (op == 7'h03);
        e       = blank(ST_ADDR);
        e.srca  = 1'b1;
        e.srcb  = 2'b10;
        e.aluop = exp_alu_op(op);
        step(idle_rdy(), rbit(), e, "addr");
        for (int k = 0; k <= mwait; k++) begin
          e      = blank(is_load ? ST_MEM_RD : ST_MEM_WR);
          e.req  = 1'b1;
          e.iord = 1'b1;
          e.wr   = !is_load;
          if (k == abort_at) begin
            do_reset(e);
            return;
          end
          step(k == mwait, rbit(), e, is_load ? "mem_rd" : "mem_wr");
          if (k != mwait && k == WAIT_MAX - 1) begin
            enter_trap(2'b10);
            return;
          end
        end
        if (is_load) begin
          e     = blank(ST_WB_MEM);
          e.rw  = 1'b1;
          e.m2r = 2'b01;
          step(idle_rdy(), rbit(), e, "wb_mem");
        end
        retire_pending = 1'b1;
      end
      7'h63: begin
        e       = blank(ST_BRANCH);
        e.pcw   = tkn;
        e.pcsrc = 2'b01;
        e.aluop = 3'b101;
        step(idle_rdy(), tkn, e, "branch");
        retire_pending = 1'b1;
      end
      7'h6F, 7'h67: begin
        e       = blank(ST_JUMP);
        e.rw    = 1'b1;
        e.m2r   = 2'b10;
        e.pcw   = 1'b1;
        e.pcsrc = (op == 7'h67) ? 2'b10 : 2'b01;
        step(idle_rdy(), rbit(), e, "jump");
        retire_pending = 1'b1;
      end
      default: begin
`ifdef ILLEGAL_TRAP_EN
        enter_trap(2'b01);
`else
        retire_pending = 1'b1;
`endif
      end
    endcase
  endtask

  // ---------------- stimulus ----------------
  initial begin
    out_t e;
    reset          = 1'b0;
    OP_i           = 7'h00;
    Mem_Ready_i    = 1'b0;
    Branch_Taken_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // Reset held with ready high: FETCH, no enables.
    e      = blank(ST_FETCH);
    e.srcb = 2'b01;
    step(1'b1, 1'b0, e, "reset_state");
    reset = 1'b1;

    rdy_one = 1'b1;
    run_instr(7'h33, 0, 0, 1'b0, -1);           // R-type, ready always high
    rdy_one = 1'b0;
    run_instr(7'h03, 0, 3, 1'b0, -1);           // load, ready after 3 waits
    run_instr(7'h63, 0, 0, 1'b0, -1);           // branch not taken
    run_instr(7'h63, 1, 0, 1'b1, -1);           // branch taken
    run_instr(7'h13, WAIT_MAX - 1, 0, 1'b0, -1); // ready on expiry cycle wins
    run_instr(7'h13, WAIT_MAX, 0, 1'b0, -1);    // fetch timeout -> trap
    run_instr(7'h17, 0, 0, 1'b0, -1);
    run_instr(7'h37, 2, 0, 1'b0, -1);
    run_instr(7'h6F, 0, 0, 1'b0, -1);
    run_instr(7'h67, 0, 0, 1'b0, -1);
    run_instr(7'h23, 0, WAIT_MAX - 1, 1'b0, -1);
    run_instr(7'h03, 0, WAIT_MAX + 1, 1'b0, -1); // data read timeout -> trap
    run_instr(7'h7F, 0, 0, 1'b0, -1);           // unknown opcode
    run_instr(7'h23, 1, 5, 1'b0, 2);            // reset during store wait
    run_instr(7'h33, 0, 0, 1'b0, -1);

    for (int n = 0; n < 150; n++) begin
      logic [6:0] op;
      int r, fw, mw, ab;
      r = $urandom_range(0, 11);
      case (r)
        0: op = 7'h33;  1: op = 7'h13;  2: op = 7'h17;  3: op = 7'h37;
        4: op = 7'h03;  5: op = 7'h23;  6: op = 7'h63;  7: op = 7'h6F;
        8: op = 7'h67;  9: op = 7'h7F;  10: op = 7'h00;
        default: op = 7'($urandom);
      endcase
      fw = ($urandom_range(0, 19) == 0) ? WAIT_MAX + $urandom_range(0, 2) : $urandom_range(0, 3);
      mw = ($urandom_range(0, 9) == 0) ? WAIT_MAX - 1 + $urandom_range(0, 2) : $urandom_range(0, 3);
      ab = ($urandom_range(0, 14) == 0) ? $urandom_range(0, 2) : -1;
      run_instr(op, fw, mw, rbit(), ab);
    end

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: got=%0d pending exp=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
